checkbits_seq_monitor: RTL and testbench
========================================

CHECKBITS_SEQ_MONITOR -- requirements
Module: checkbits_seq_monitor

Interface
REQ-001 Parameter WIDTH, default 16: width of the monitored checkbits field.
REQ-002 Parameter STEPS, default 2: number of signature words in the expected sequence; range 1..8.
REQ-003 Parameter STABLE_CYCLES, default 2: consecutive identical samples needed to qualify a value; minimum 1.
REQ-004 Parameter TIMEOUT_CYCLES, default 150000: maximum cycles allowed between arming or a match and the next match.
REQ-005 wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 wb_rst_i  input  1  reset, synchronous and active-high.
REQ-007 start_i  input  1  arm pulse; clears status and starts the sequence at step 0.
REQ-008 strict_i  input  1  sampled at arm; 1 = an unexpected qualified value fails the run.
REQ-009 checkbits_i  input  WIDTH  monitored field, e.g. mprj_io[31:16].
REQ-010 mask_i  input  WIDTH  1 = bit takes part in compares.
REQ-011 exp_seq_i  input  STEPS*WIDTH  step k expected word at [k*WIDTH +: WIDTH].
REQ-012 busy_o  output  1  high while armed.
REQ-013 pass_o, fail_o, timeout_o  output  1 each  sticky result flags.
REQ-014 step_o  output  clog2(STEPS+1)  number of steps matched so far.
REQ-015 cycles_o  output  32  cycles elapsed in the current step; saturates.

Function
REQ-016 FSM states: IDLE, ARMED, PASS, FAIL.
REQ-017 IDLE->ARMED on start_i. PASS->ARMED and FAIL->ARMED on start_i. start_i in ARMED is ignored.
REQ-018 Arming clears step_o, cycles_o, pass_o, fail_o, timeout_o and the stability filter, and latches strict_i.
REQ-019 checkbits_i is registered once (in_q) before any compare; comparisons use in_q & mask_i.
REQ-020 Filter: a counter loads 1 when the masked in_q differs from the previous masked in_q, and otherwise increments, saturating at STABLE_CYCLES.
REQ-021 A qualify event is a single-cycle pulse, generated only on the cycle the filter counter reaches STABLE_CYCLES.
REQ-022 A value held constant from edge E is qualified at edge E+STABLE_CYCLES, and step_o updates at edge E+STABLE_CYCLES+1.
REQ-023 In ARMED, a qualify event with masked value == masked exp[step]: step_o increments and cycles_o resets to 0.
REQ-024 When step_o reaches STEPS, the FSM enters PASS, sets pass_o and drops busy_o on the same edge.
REQ-025 In ARMED with strict latched, a qualify event whose value matches neither exp[step] nor exp[step-1] enters FAIL. At step 0 any value is tolerated.
REQ-026 In ARMED, cycles_o increments each cycle. On reaching TIMEOUT_CYCLES the FSM enters FAIL and sets fail_o and timeout_o.
REQ-027 If a match and the timeout fall on the same cycle, the match wins.
REQ-028 A strict mismatch sets fail_o only; timeout_o stays 0.
REQ-029 The filter keeps running in IDLE, PASS and FAIL; a value already stable at arm is not re-qualified until it changes.
REQ-030 pass_o and fail_o are never both 1.

Reset
REQ-031 wb_rst_i=1 at an edge forces IDLE and sets every output, counter and in_q to 0.
REQ-032 Reset mid-run discards progress, and reset takes priority over start_i.

Structure
REQ-033 A shared package holds the FSM state enum, the step-width function and the 32-bit counter width constant.
REQ-034 The stability filter is one sub-module, checkbits_stable_filter (in, mask -> qualify pulse, qualified value).

Verification
REQ-035 Defaults, exp={AB61,AB60}, mask FFFF: drive AB60 then AB61, each for 5 cycles -> step_o 1 then 2, pass_o=1, fail_o=0.
REQ-036 STABLE_CYCLES=3: AB60 held 2 cycles then 0000 -> no step; AB60 held 3 cycles -> step_o=1 on the following edge.
REQ-037 TIMEOUT_CYCLES=100, arm, hold 0000 -> fail_o=1 and timeout_o=1 at cycle 100, busy_o=0.
REQ-038 strict=1: AB60 then 1234 -> fail_o=1, timeout_o=0, step_o=1. With strict=0 the same stimulus -> still ARMED.
REQ-039 mask=FF00, exp[0]=AB00: drive AB7F -> step_o=1. Match and timeout on the same cycle -> step increments and no fail.
REQ-040 Assert wb_rst_i with step_o=1 -> all outputs 0. Then start_i together with wb_rst_i -> stays IDLE.

Source files
------------

// File: rtl/checkbits_seq_monitor_pkg.sv
// Shared definitions for the checkbits sequence monitor.
//   mon_state_t : monitor FSM states
//   step_width  : width of the step counter for a given sequence length
//   CNT_W       : width of the per-step cycle counter
package checkbits_seq_monitor_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } mon_state_t;

  // step_o must be able to hold the value STEPS itself (sequence complete).
  function automatic int unsigned step_width(input int unsigned steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/checkbits_seq_monitor_stable_filter.sv
// Stability filter for the monitored checkbits field.
// Registers the raw field once, then counts consecutive identical masked
// samples. A one-cycle qualify pulse is produced when the count reaches
// STABLE_CYCLES, together with the masked value that qualified.
//   clock, reset : clock and synchronous active-high reset
//   clear        : suppresses a qualify pulse on the arming edge
//   checkbits    : raw monitored field
//   mask         : 1 = bit takes part in the compare
//   qualify      : single-cycle pulse, value is stable
//   value        : masked value that qualified (valid with qualify)
module checkbits_stable_filter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] checkbits,
  input  logic [WIDTH-1:0] mask,
  output logic             qualify,
  output logic [WIDTH-1:0] value
);

  localparam int unsigned   FW     = $clog2(STABLE_CYCLES + 1);
  localparam logic [FW-1:0] SAT    = FW'(STABLE_CYCLES);
  localparam logic [FW-1:0] SAT_M1 = FW'(STABLE_CYCLES - 1);
  localparam logic          SINGLE = (STABLE_CYCLES == 1);

  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] masked;
  logic [FW-1:0]    cnt_q;
  logic [FW-1:0]    cnt_d;
  logic             changed;
  logic             hit;

  always_comb begin
    masked  = in_q & mask;
    changed = (masked != prev_q);
    cnt_d   = cnt_q;
    if (changed) begin
      cnt_d = FW'(1);
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + FW'(1);
    end
    // The counter passes through STABLE_CYCLES-1 exactly once per new value,
    // so this fires once and a saturated value never re-qualifies.
    hit = changed ? SINGLE : (cnt_q == SAT_M1);
  end

  // clear only drops the pending pulse: the counter and history are kept so a
  // value that was already stable before arming is not qualified again.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q    <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      qualify <= 1'b0;
      value   <= '0;
    end else begin
      in_q    <= checkbits;
      prev_q  <= masked;
      cnt_q   <= cnt_d;
      qualify <= hit & ~clear;
      if (hit) begin
        value <= masked;
      end
    end
  end

endmodule

// File: rtl/checkbits_seq_monitor.sv
// Checkbits sequence monitor.
// Watches a (masked) checkbits field and checks that it steps through STEPS
// expected signature words, each one qualified by the stability filter, with
// at most TIMEOUT_CYCLES cycles between arming/previous match and next match.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   start_i            : arm pulse (ignored while armed)
//   strict_i           : latched at arm; unexpected stable value fails the run
//   checkbits_i        : monitored field
//   mask_i             : compare mask, 1 = bit compared
//   exp_seq_i          : expected word k at [k*WIDTH +: WIDTH]
//   busy_o             : armed
//   pass_o, fail_o     : sticky run result
//   timeout_o          : sticky, failure was a timeout
//   step_o             : number of steps matched
//   cycles_o           : cycles spent in the current step (saturating)
module checkbits_seq_monitor
  import checkbits_seq_monitor_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned STEPS          = 2,
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 150000
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          start_i,
  input  logic                          strict_i,
  input  logic [WIDTH-1:0]              checkbits_i,
  input  logic [WIDTH-1:0]              mask_i,
  input  logic [STEPS*WIDTH-1:0]        exp_seq_i,
  output logic                          busy_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic                          timeout_o,
  output logic [step_width(STEPS)-1:0]  step_o,
  output logic [CNT_W-1:0]              cycles_o
);

  localparam int unsigned    SW   = step_width(STEPS);
  localparam logic [SW-1:0]  LAST = SW'(STEPS - 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  mon_state_t       state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cycles_inc;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;
  logic             strict_q, strict_d;

  logic             arm;
  logic             qualify;
  logic [WIDTH-1:0] qvalue;
  logic [WIDTH-1:0] exp_cur;
  logic [WIDTH-1:0] exp_prev;
  logic             match;
  logic             prev_match;

  assign arm = start_i && (state_q != ST_ARMED);

  checkbits_stable_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clock     (wb_clk_i),
    .reset     (wb_rst_i),
    .clear     (arm),
    .checkbits (checkbits_i),
    .mask      (mask_i),
    .qualify   (qualify),
    .value     (qvalue)
  );

  // Select the word expected at the current step and the one just matched.
  always_comb begin
    exp_cur  = '0;
    exp_prev = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      if (step_q == SW'(k)) begin
        exp_cur = exp_seq_i[k*WIDTH +: WIDTH];
      end
      if (step_q == SW'(k + 1)) begin
        exp_prev = exp_seq_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    match      = qualify && (qvalue == (exp_cur & mask_i));
    prev_match = (step_q != '0) && (qvalue == (exp_prev & mask_i));
    cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cycles_d = cycles_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    strict_d = strict_q;
    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start_i) begin
          state_d  = ST_ARMED;
          step_d   = '0;
          cycles_d = '0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          tmo_d    = 1'b0;
          strict_d = strict_i;
        end
      end
      ST_ARMED: begin
        cycles_d = cycles_inc;
        // Priority: match, then strict mismatch, then timeout.
        if (match) begin
          step_d   = step_q + SW'(1);
          cycles_d = '0;
          if (step_q == LAST) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end
        end else if (qualify && strict_q && (step_q != '0) && !prev_match) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end else if (cycles_inc >= TMO) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      cycles_q <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      tmo_q    <= 1'b0;
      strict_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cycles_q <= cycles_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      tmo_q    <= tmo_d;
      strict_q <= strict_d;
    end
  end

  assign busy_o    = (state_q == ST_ARMED);
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign timeout_o = tmo_q;
  assign step_o    = step_q;
  assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Self-checking bench for checkbits_seq_monitor. Three instances share the
// stimulus: a = defaults, b = STABLE_CYCLES 3, c = TIMEOUT_CYCLES 100.
module tb_checkbits_seq_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic        strict;
  logic [15:0] chk;
  logic [15:0] mask;
  logic [31:0] exp_seq;

  logic        busy_a, pass_a, fail_a, tmo_a;
  logic        busy_b, pass_b, fail_b, tmo_b;
  logic        busy_c, pass_c, fail_c, tmo_c;
  logic [1:0]  step_a, step_b, step_c;
  logic [31:0] cyc_a, cyc_b, cyc_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        strict;
    logic [15:0] chk;
    logic [15:0] mask;
    logic [31:0] exp_seq;
    int          hold;
    int          dut;
    logic [1:0]  e_step;
    logic        e_pass;
    logic        e_fail;
    logic        e_tmo;
    logic        e_busy;
    int          e_cyc;
  } row_t;

  typedef struct {
    int          dut;
    int          id;
    logic [1:0]  step;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic        busy;
    int          cyc;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];

  checkbits_seq_monitor dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .strict_i(strict),
    .checkbits_i(chk), .mask_i(mask), .exp_seq_i(exp_seq),
    .busy_o(busy_a), .pass_o(pass_a), .fail_o(fail_a), .timeout_o(tmo_a),
    .step_o(step_a), .cycles_o(cyc_a)
  );

  checkbits_seq_monitor #(.STABLE_CYCLES(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .strict_i(strict),
    .checkbits_i(chk), .mask_i(mask), .exp_seq_i(exp_seq),
    .busy_o(busy_b), .pass_o(pass_b), .fail_o(fail_b), .timeout_o(tmo_b),
    .step_o(step_b), .cycles_o(cyc_b)
  );

  checkbits_seq_monitor #(.TIMEOUT_CYCLES(100)) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .strict_i(strict),
    .checkbits_i(chk), .mask_i(mask), .exp_seq_i(exp_seq),
    .busy_o(busy_c), .pass_o(pass_c), .fail_o(fail_c), .timeout_o(tmo_c),
    .step_o(step_c), .cycles_o(cyc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    logic [1:0]  gs;
    logic        gp, gf, gt, gb;
    logic [31:0] gc;
    case (e.dut)
      1:       begin gs = step_b; gp = pass_b; gf = fail_b; gt = tmo_b; gb = busy_b; gc = cyc_b; end
      2:       begin gs = step_c; gp = pass_c; gf = fail_c; gt = tmo_c; gb = busy_c; gc = cyc_c; end
      default: begin gs = step_a; gp = pass_a; gf = fail_a; gt = tmo_a; gb = busy_a; gc = cyc_a; end
    endcase
    checks++;
    if ({gs, gp, gf, gt, gb} !== {e.step, e.pass, e.fail, e.tmo, e.busy}) begin
      errors++;
      $display("FAIL state id=%0d dut=%0d: got step=%0d pass=%0b fail=%0b timeout=%0b busy=%0b, want step=%0d pass=%0b fail=%0b timeout=%0b busy=%0b",
               e.id, e.dut, gs, gp, gf, gt, gb, e.step, e.pass, e.fail, e.tmo, e.busy);
    end
    if (e.cyc >= 0) begin
      checks++;
      if (gc !== 32'(e.cyc)) begin
        errors++;
        $display("FAIL cycles id=%0d dut=%0d: got %0d, want %0d", e.id, e.dut, gc, e.cyc);
      end
    end
  endtask

  // Scoreboard consumer: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      check(sb.pop_front());
    end
  end

  task automatic drive(input logic r, input logic s, input logic st,
                       input logic [15:0] c, input logic [15:0] m,
                       input logic [31:0] e, input int hold);
    rst = r; start = s; strict = st; chk = c; mask = m; exp_seq = e;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input int dut, input int id, input logic [1:0] s,
                          input logic p, input logic f, input logic t,
                          input logic b, input int c);
    exp_t e;
    e = '{dut, id, s, p, f, t, b, c};
    sb.push_back(e);
  endtask

  task automatic add(input logic r, input logic s, input logic st,
                     input logic [15:0] c, input logic [15:0] m,
                     input logic [31:0] e, input int hold, input int dut,
                     input logic [1:0] es, input logic ep, input logic ef,
                     input logic et, input logic eb, input int ec);
    row_t x;
    x = '{r, s, st, c, m, e, hold, dut, es, ep, ef, et, eb, ec};
    rows.push_back(x);
  endtask

  localparam logic [15:0] MF = 16'hFFFF;
  localparam logic [15:0] MH = 16'hFF00;
  localparam logic [31:0] EA = 32'hAB61_AB60;
  localparam logic [31:0] EM = 32'hAB61_AB00;

  initial begin
    rst = 1'b1; start = 1'b0; strict = 1'b0; chk = '0; mask = MF; exp_seq = EA;

    //   rst st  str chk       mask exp hold dut step p  f  t  busy cyc
    // two-step sequence to PASS
    add(1, 0, 0, 16'h0000, MF, EA, 2,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0000, MF, EA, 1,   0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16'hAB60, MF, EA, 5,   0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 16'hAB61, MF, EA, 5,   0, 2, 1, 0, 0, 0, 0);
    // strict mismatch from PASS re-arm
    add(0, 1, 1, 16'h0000, MF, EA, 1,   0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16'hAB60, MF, EA, 5,   0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 16'h1234, MF, EA, 5,   0, 1, 0, 1, 0, 0, -1);
    // non-strict, re-armed from FAIL
    add(0, 1, 0, 16'h0000, MF, EA, 1,   0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16'hAB60, MF, EA, 5,   0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 16'h1234, MF, EA, 5,   0, 1, 0, 0, 0, 1, 6);
    // masked compare
    add(1, 0, 0, 16'h0000, MF, EA, 1,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0000, MH, EM, 1,   0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16'hAB7F, MH, EM, 5,   0, 1, 0, 0, 0, 1, 1);
    // reset mid-run, then reset wins over start
    add(1, 0, 0, 16'h0000, MF, EA, 1,   0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 16'h0000, MF, EA, 1,   0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, MF, EA, 2,   0, 0, 0, 0, 0, 0, 0);
    // STABLE_CYCLES=3 boundary
    add(1, 0, 0, 16'h0000, MF, EA, 1,   1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0000, MF, EA, 1,   1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16'hAB60, MF, EA, 2,   1, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 16'h0000, MF, EA, 3,   1, 0, 0, 0, 0, 1, 5);
    add(0, 0, 0, 16'hAB60, MF, EA, 3,   1, 0, 0, 0, 0, 1, 8);
    add(0, 0, 0, 16'h0000, MF, EA, 1,   1, 0, 0, 0, 0, 1, 9);
    add(0, 0, 0, 16'h0000, MF, EA, 1,   1, 1, 0, 0, 0, 1, 0);
    // TIMEOUT_CYCLES=100
    add(1, 0, 0, 16'h0000, MF, EA, 1,   2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0000, MF, EA, 1,   2, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16'h0000, MF, EA, 99,  2, 0, 0, 0, 0, 1, 99);
    add(0, 0, 0, 16'h0000, MF, EA, 1,   2, 0, 0, 1, 1, 0, 100);
    // match lands on the timeout cycle
    add(1, 0, 0, 16'h0000, MF, EA, 1,   2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0000, MH, EM, 1,   2, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16'h0000, MH, EM, 96,  2, 0, 0, 0, 0, 1, 96);
    add(0, 0, 0, 16'hAB7F, MH, EM, 3,   2, 0, 0, 0, 0, 1, 99);
    add(0, 0, 0, 16'hAB7F, MH, EM, 1,   2, 1, 0, 0, 0, 1, 0);

    for (int i = 0; i < rows.size(); i++) begin
      row_t r;
      r = rows[i];
      drive(r.rst, r.start, r.strict, r.chk, r.mask, r.exp_seq, r.hold);
      exp_push(r.dut, i, r.e_step, r.e_pass, r.e_fail, r.e_tmo, r.e_busy, r.e_cyc);
    end

    // Value already stable before arming must not count as a match.
    drive(1, 0, 0, 16'hAB60, MF, EA, 1);
    exp_push(0, 100, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 16'hAB60, MF, EA, 6);
    exp_push(0, 101, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 16'hAB60, MF, EA, 1);
    exp_push(0, 102, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 16'hAB60, MF, EA, 6);
    exp_push(0, 103, 0, 0, 0, 0, 1, 6);
    // After a change it qualifies normally.
    drive(0, 0, 0, 16'h0000, MF, EA, 4);
    drive(0, 0, 0, 16'hAB60, MF, EA, 5);
    exp_push(0, 104, 1, 0, 0, 0, 1, 1);
    // start while armed is ignored.
    drive(0, 1, 0, 16'hAB60, MF, EA, 1);
    exp_push(0, 105, 1, 0, 0, 0, 1, 2);
    drive(0, 0, 0, 16'hAB60, MF, EA, 1);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
